// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader
// Loads a program into a local instruction memory, then holds a core out of
// reset while it fetches from that memory. A run ends on a HALT opcode or on
// the run-cycle watchdog.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   load_start               pulse: begin a program load (IDLE only)
//   load_valid/ready/data    loader word handshake; load_ready=1 only in LOAD
//   load_last                marks the final program word
//   run_start                pulse: begin or restart a run (IDLE/HALTED)
//   pc                       core fetch address
//   instr                    registered fetched instruction (latency 1)
//   cpu_nrst                 active-low core reset, 1 only while in RUN
//   prog_len                 number of words in the loaded program
//   halted, timeout          how the last run ended
//   err_ovf, err_oob         sticky load-overflow / out-of-range-fetch flags
//   cycles                   run-cycle count of the current or last run
module prog_loader #(
    parameter int                 A_BITS     = 10,
    parameter int                 I_BITS     = 16,
    parameter int                 OP_BITS    = 7,
    parameter logic [OP_BITS-1:0] HALT_OPC   = 7'h7F,
    parameter int                 CNT_BITS   = 24,
    parameter int                 MAX_CYCLES = 900
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [I_BITS-1:0]   load_data,
    input  logic                load_last,
    input  logic                run_start,
    input  logic [A_BITS-1:0]   pc,
    output logic [I_BITS-1:0]   instr,
    output logic                cpu_nrst,
    output logic [A_BITS:0]     prog_len,
    output logic                halted,
    output logic                timeout,
    output logic                err_ovf,
    output logic                err_oob,
    output logic [CNT_BITS-1:0] cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALTED
    } state_t;

    localparam logic [A_BITS-1:0]   PTR_MAX   = '1;
    localparam logic [A_BITS:0]     MEM_WORDS = {1'b1, {A_BITS{1'b0}}};
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [CNT_BITS-1:0] TO_LIMIT  =
        CNT_BITS'((MAX_CYCLES > 0) ? (MAX_CYCLES - 1) : 0);

    state_t              state_q, state_d;
    logic [A_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [A_BITS:0]     prog_len_q, prog_len_d;
    logic [I_BITS-1:0]   instr_q, instr_d;
    logic                fetch_vld_q, fetch_vld_d;
    logic                cpu_nrst_q;
    logic [CNT_BITS-1:0] cycles_q, cycles_d, cycles_inc;
    logic                halted_q, halted_d;
    logic                timeout_q, timeout_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_oob_q, err_oob_d;

    logic [I_BITS-1:0]   mem [2**A_BITS];
    logic                mem_we;

    logic                pc_oob;
    logic                halt_hit;
    logic                timeout_hit;

    assign pc_oob     = ({1'b0, pc} >= prog_len_q);
    assign cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_BITS'(1);

    // instr_q still holds the last word of the previous run when a run is
    // restarted; fetch_vld_q masks it until the first fetch of this run lands.
    assign halt_hit    = fetch_vld_q && (instr_q[I_BITS-1 -: OP_BITS] == HALT_OPC);
    // Compared against the post-edge count so the run leaves RUN on the same
    // edge that makes cycles reach MAX_CYCLES-1.
    assign timeout_hit = (MAX_CYCLES != 0) && (cycles_inc >= TO_LIMIT);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        prog_len_d  = prog_len_q;
        instr_d     = instr_q;
        fetch_vld_d = fetch_vld_q;
        cycles_d    = cycles_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        err_ovf_d   = err_ovf_q;
        err_oob_d   = err_oob_q;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if ((state_q == S_IDLE) && load_start) begin
                    state_d    = S_LOAD;
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                    err_ovf_d  = 1'b0;
                    err_oob_d  = 1'b0;
                end else if (run_start && (prog_len_q != '0)) begin
                    state_d     = S_RUN;
                    cycles_d    = '0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                    fetch_vld_d = 1'b0;
                end
            end

            S_LOAD: begin
                if (load_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + A_BITS'(1);
                    if (load_last) begin
                        prog_len_d = {1'b0, wr_ptr_q} + (A_BITS + 1)'(1);
                        state_d    = S_IDLE;
                    end else if (wr_ptr_q == PTR_MAX) begin
                        prog_len_d = MEM_WORDS;
                        err_ovf_d  = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            S_RUN: begin
                cycles_d    = cycles_inc;
                fetch_vld_d = 1'b1;
                if (pc_oob) begin
                    instr_d   = '0;
                    err_oob_d = 1'b1;
                end else begin
                    instr_d = mem[pc];
                end
                if (halt_hit) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = S_HALTED;
                    timeout_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            prog_len_q  <= '0;
            instr_q     <= '0;
            fetch_vld_q <= 1'b0;
            cpu_nrst_q  <= 1'b0;
            cycles_q    <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            prog_len_q  <= prog_len_d;
            instr_q     <= instr_d;
            fetch_vld_q <= fetch_vld_d;
            cpu_nrst_q  <= (state_d == S_RUN);
            cycles_q    <= cycles_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            err_ovf_q   <= err_ovf_d;
            err_oob_q   <= err_oob_d;
        end
    end

    // Program memory is deliberately outside the reset domain so a loaded
    // program survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= load_data;
        end
    end

    assign load_ready = (state_q == S_LOAD);
    assign instr      = instr_q;
    assign cpu_nrst   = cpu_nrst_q;
    assign prog_len   = prog_len_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign err_ovf    = err_ovf_q;
    assign err_oob    = err_oob_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance, default parameters
    logic        m_load_start, m_load_valid, m_load_ready, m_load_last, m_run_start;
    logic [15:0] m_load_data, m_instr;
    logic [9:0]  m_pc;
    logic        m_cpu_nrst, m_halted, m_timeout, m_err_ovf, m_err_oob;
    logic [10:0] m_prog_len;
    logic [23:0] m_cycles;

    // small instance: 8-word memory, 4-bit counter, watchdog off
    logic        s_load_start, s_load_valid, s_load_ready, s_load_last, s_run_start;
    logic [15:0] s_load_data, s_instr;
    logic [2:0]  s_pc;
    logic        s_cpu_nrst, s_halted, s_timeout, s_err_ovf, s_err_oob;
    logic [3:0]  s_prog_len;
    logic [3:0]  s_cycles;

    prog_loader u_main (
        .clk(clk), .rst(rst),
        .load_start(m_load_start), .load_valid(m_load_valid), .load_ready(m_load_ready),
        .load_data(m_load_data), .load_last(m_load_last), .run_start(m_run_start),
        .pc(m_pc), .instr(m_instr), .cpu_nrst(m_cpu_nrst), .prog_len(m_prog_len),
        .halted(m_halted), .timeout(m_timeout), .err_ovf(m_err_ovf), .err_oob(m_err_oob),
        .cycles(m_cycles)
    );

    prog_loader #(.A_BITS(3), .CNT_BITS(4), .MAX_CYCLES(0)) u_small (
        .clk(clk), .rst(rst),
        .load_start(s_load_start), .load_valid(s_load_valid), .load_ready(s_load_ready),
        .load_data(s_load_data), .load_last(s_load_last), .run_start(s_run_start),
        .pc(s_pc), .instr(s_instr), .cpu_nrst(s_cpu_nrst), .prog_len(s_prog_len),
        .halted(s_halted), .timeout(s_timeout), .err_ovf(s_err_ovf), .err_oob(s_err_oob),
        .cycles(s_cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mm [1024];
    logic [15:0] sm [8];
    logic [15:0] exp_q [$];
    logic [15:0] ev;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // non-HALT word: bit 15 clear keeps the opcode below 7'h40
    function automatic logic [15:0] nh(input int i);
        nh = 16'((i * 291 + 165) & 32'h7FFF);
    endfunction

    // drives n words into a main instance already in LOAD, last word flagged
    task automatic load_words(input int n, input int halt_idx, input int seed);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = (i == halt_idx) ? {7'h7F, 9'(i)} : nh(i + seed);
            mm[i] = w;
            m_load_valid = 1'b1;
            m_load_data  = w;
            m_load_last  = (i == n - 1);
            tick();
        end
        m_load_valid = 1'b0;
        m_load_last  = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_tests++; if (m_load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_load_ready: got %b exp 0", m_load_ready); end
        n_tests++; if (m_cpu_nrst !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_nrst: got %b exp 0", m_cpu_nrst); end
        n_tests++; if (m_instr !== 16'h0) begin n_fail++; $display("FAIL rst_instr: got %h exp 0", m_instr); end
        n_tests++; if (m_prog_len !== 11'd0) begin n_fail++; $display("FAIL rst_prog_len: got %0d exp 0", m_prog_len); end
        n_tests++; if (m_cycles !== 24'd0) begin n_fail++; $display("FAIL rst_cycles: got %0d exp 0", m_cycles); end
        n_tests++; if ({m_halted, m_timeout, m_err_ovf, m_err_oob} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b exp 0000", {m_halted, m_timeout, m_err_ovf, m_err_oob}); end
        n_tests++; if (s_load_ready !== 1'b0 || s_prog_len !== 4'd0) begin n_fail++; $display("FAIL rst_small: got rdy=%b len=%0d exp 0/0", s_load_ready, s_prog_len); end
        rst = 1'b0;
        tick();
        m_run_start = 1'b1; tick(); m_run_start = 1'b0; tick();
        n_tests++; if (m_cpu_nrst !== 1'b0) begin n_fail++; $display("FAIL empty_run_ignored: got cpu_nrst=%b exp 0", m_cpu_nrst); end
    endtask

    task automatic test_overflow();
        s_load_start = 1'b1; tick(); s_load_start = 1'b0;
        n_tests++; if (s_load_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready: got %b exp 1", s_load_ready); end
        for (int i = 0; i < 8; i++) begin
            sm[i] = 16'((i * 801 + 17) & 32'h7FFF);
            s_load_valid = 1'b1; s_load_data = sm[i]; s_load_last = 1'b0;
            if (i == 7) begin
                n_tests++; if (s_load_ready !== 1'b1 || s_err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before_last: got rdy=%b ovf=%b exp 1/0", s_load_ready, s_err_ovf); end
            end
            tick();
        end
        s_load_valid = 1'b0;
        n_tests++; if (s_err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", s_err_ovf); end
        n_tests++; if (s_prog_len !== 4'd8) begin n_fail++; $display("FAIL ovf_prog_len: got %0d exp 8", s_prog_len); end
        n_tests++; if (s_load_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_after: got %b exp 0", s_load_ready); end
        // ninth word must be refused; it would otherwise land on mem[0]
        s_load_valid = 1'b1; s_load_data = 16'h5EAD; tick(); s_load_valid = 1'b0;
        n_tests++; if (s_prog_len !== 4'd8 || s_load_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ninth: got len=%0d rdy=%b exp 8/0", s_prog_len, s_load_ready); end
        s_pc = '0; s_run_start = 1'b1; tick(); s_run_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(sm[0]);
            tick();
            ev = exp_q.pop_front();
            n_tests++; if (s_instr !== ev) begin n_fail++; $display("FAIL small_instr[%0d]: got %h exp %h", k, s_instr, ev); end
        end
        n_tests++; if (s_cycles !== 4'd15) begin n_fail++; $display("FAIL cycles_saturate: got %0d exp 15", s_cycles); end
        n_tests++; if (s_cpu_nrst !== 1'b1 || s_timeout !== 1'b0) begin n_fail++; $display("FAIL no_watchdog: got nrst=%b to=%b exp 1/0", s_cpu_nrst, s_timeout); end
    endtask

    task automatic test_load();
        m_load_start = 1'b1; tick(); m_load_start = 1'b0;
        n_tests++; if (m_load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_on: got %b exp 1", m_load_ready); end
        for (int i = 0; i < 14; i++) begin
            mm[i] = (i == 13) ? {7'h7F, 9'(i)} : nh(i);
            m_load_valid = 1'b1; m_load_data = mm[i]; m_load_last = (i == 13);
            tick();
            m_load_valid = 1'b0; m_load_last = 1'b0;
            if (i < 13) begin
                n_tests++; if (m_load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_mid[%0d]: got %b exp 1", i, m_load_ready); end
                if (i % 3 == 0) tick();
            end
        end
        n_tests++; if (m_prog_len !== 11'd14) begin n_fail++; $display("FAIL load_prog_len: got %0d exp 14", m_prog_len); end
        n_tests++; if (m_load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_off: got %b exp 0", m_load_ready); end
        n_tests++; if (m_err_ovf !== 1'b0) begin n_fail++; $display("FAIL load_err_ovf: got %b exp 0", m_err_ovf); end
    endtask

    task automatic test_run_halt();
        m_pc = '0; m_run_start = 1'b1; tick(); m_run_start = 1'b0;
        n_tests++; if (m_cpu_nrst !== 1'b1 || m_cycles !== 24'd0) begin n_fail++; $display("FAIL run_entry: got nrst=%b cyc=%0d exp 1/0", m_cpu_nrst, m_cycles); end
        for (int k = 0; k < 14; k++) begin
            m_pc = 10'(k);
            exp_q.push_back(mm[k]);
            tick();
            ev = exp_q.pop_front();
            n_tests++; if (m_instr !== ev) begin n_fail++; $display("FAIL run_instr[%0d]: got %h exp %h", k, m_instr, ev); end
        end
        n_tests++; if (m_halted !== 1'b0 || m_cpu_nrst !== 1'b1) begin n_fail++; $display("FAIL halt_early: got h=%b nrst=%b exp 0/1", m_halted, m_cpu_nrst); end
        tick();
        n_tests++; if (m_halted !== 1'b1 || m_timeout !== 1'b0) begin n_fail++; $display("FAIL halt_flags: got h=%b to=%b exp 1/0", m_halted, m_timeout); end
        n_tests++; if (m_cpu_nrst !== 1'b0) begin n_fail++; $display("FAIL halt_nrst: got %b exp 0", m_cpu_nrst); end
        n_tests++; if (m_cycles !== 24'd15) begin n_fail++; $display("FAIL halt_cycles: got %0d exp 15", m_cycles); end
        n_tests++; if (m_err_oob !== 1'b0) begin n_fail++; $display("FAIL halt_oob: got %b exp 0", m_err_oob); end
        m_pc = 10'd3; tick(); tick();
        n_tests++; if (m_cycles !== 24'd15 || m_instr !== mm[13]) begin n_fail++; $display("FAIL halted_hold: got cyc=%0d instr=%h exp 15/%h", m_cycles, m_instr, mm[13]); end
    endtask

    task automatic test_restart();
        m_load_start = 1'b1; tick(); m_load_start = 1'b0;
        n_tests++; if (m_load_ready !== 1'b0 || m_prog_len !== 11'd14) begin n_fail++; $display("FAIL halted_load_ignored: got rdy=%b len=%0d exp 0/14", m_load_ready, m_prog_len); end
        m_pc = '0; m_run_start = 1'b1; tick(); m_run_start = 1'b0;
        n_tests++; if (m_cpu_nrst !== 1'b1 || m_halted !== 1'b0 || m_cycles !== 24'd0) begin n_fail++; $display("FAIL restart: got nrst=%b h=%b cyc=%0d exp 1/0/0", m_cpu_nrst, m_halted, m_cycles); end
        m_pc = 10'd20; exp_q.push_back(16'h0); tick();
        ev = exp_q.pop_front();
        n_tests++; if (m_instr !== ev || m_err_oob !== 1'b1) begin n_fail++; $display("FAIL oob14: got instr=%h oob=%b exp %h/1", m_instr, m_err_oob, ev); end
        m_pc = 10'd2; exp_q.push_back(mm[2]); tick();
        ev = exp_q.pop_front();
        n_tests++; if (m_instr !== ev || m_err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_sticky: got instr=%h oob=%b exp %h/1", m_instr, m_err_oob, ev); end
        n_tests++; if (m_halted !== 1'b0 || m_cpu_nrst !== 1'b1) begin n_fail++; $display("FAIL stale_halt: got h=%b nrst=%b exp 0/1", m_halted, m_cpu_nrst); end
        m_pc = 10'd13; exp_q.push_back(mm[13]); tick();
        ev = exp_q.pop_front();
        n_tests++; if (m_instr !== ev) begin n_fail++; $display("FAIL restart_instr: got %h exp %h", m_instr, ev); end
        tick();
        n_tests++; if (m_halted !== 1'b1 || m_cycles !== 24'd4) begin n_fail++; $display("FAIL restart_halt: got h=%b cyc=%0d exp 1/4", m_halted, m_cycles); end
    endtask

    task automatic test_rst_mid();
        m_pc = 10'd1; m_run_start = 1'b1; tick(); m_run_start = 1'b0; tick(); tick();
        n_tests++; if (m_cpu_nrst !== 1'b1) begin n_fail++; $display("FAIL pre_rst_run: got %b exp 1", m_cpu_nrst); end
        #3 rst = 1'b1;
        #1;
        n_tests++; if (m_cpu_nrst !== 1'b0) begin n_fail++; $display("FAIL async_rst_nrst: got %b exp 0", m_cpu_nrst); end
        n_tests++; if (m_cycles !== 24'd0 || m_instr !== 16'h0 || m_prog_len !== 11'd0) begin n_fail++; $display("FAIL async_rst_vals: got cyc=%0d instr=%h len=%0d exp 0/0/0", m_cycles, m_instr, m_prog_len); end
        n_tests++; if ({m_halted, m_timeout, m_err_ovf, m_err_oob, m_load_ready} !== 5'b0) begin n_fail++; $display("FAIL async_rst_flags: got %b exp 00000", {m_halted, m_timeout, m_err_ovf, m_err_oob, m_load_ready}); end
        tick(); rst = 1'b0; tick();
        m_load_start = 1'b1; tick(); m_load_start = 1'b0;
        m_load_valid = 1'b1; m_load_data = 16'h1234; tick(); tick(); m_load_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        n_tests++; if (m_prog_len !== 11'd0 || m_load_ready !== 1'b0) begin n_fail++; $display("FAIL load_abort: got len=%0d rdy=%b exp 0/0", m_prog_len, m_load_ready); end
        m_run_start = 1'b1; tick(); m_run_start = 1'b0; tick();
        n_tests++; if (m_cpu_nrst !== 1'b0) begin n_fail++; $display("FAIL abort_run_ignored: got %b exp 0", m_cpu_nrst); end
    endtask

    task automatic test_same_cycle_oob();
        m_load_start = 1'b1; tick(); m_load_start = 1'b0;
        load_words(4, -1, 100);
        n_tests++; if (m_prog_len !== 11'd4) begin n_fail++; $display("FAIL len4_first: got %0d exp 4", m_prog_len); end
        m_load_start = 1'b1; m_run_start = 1'b1; tick(); m_load_start = 1'b0; m_run_start = 1'b0;
        n_tests++; if (m_load_ready !== 1'b1 || m_cpu_nrst !== 1'b0 || m_prog_len !== 11'd0) begin n_fail++; $display("FAIL load_wins: got rdy=%b nrst=%b len=%0d exp 1/0/0", m_load_ready, m_cpu_nrst, m_prog_len); end
        load_words(4, -1, 200);
        n_tests++; if (m_prog_len !== 11'd4) begin n_fail++; $display("FAIL len4_second: got %0d exp 4", m_prog_len); end
        m_run_start = 1'b1; tick(); m_run_start = 1'b0;
        m_pc = 10'd6; exp_q.push_back(16'h0); tick();
        ev = exp_q.pop_front();
        n_tests++; if (m_instr !== ev || m_err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_pc6: got instr=%h oob=%b exp %h/1", m_instr, m_err_oob, ev); end
        m_pc = 10'd2; exp_q.push_back(mm[2]); tick();
        ev = exp_q.pop_front();
        n_tests++; if (m_instr !== ev || m_err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_pc2: got instr=%h oob=%b exp %h/1", m_instr, m_err_oob, ev); end
    endtask

    task automatic test_timeout();
        int  edges;
        bit  done;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        m_load_start = 1'b1; tick(); m_load_start = 1'b0;
        load_words(2, 1, 50);
        m_pc = '0; m_run_start = 1'b1; tick(); m_run_start = 1'b0;
        edges = 0; done = 1'b0;
        for (int j = 1; j <= 1000 && !done; j++) begin
            exp_q.push_back(mm[0]);
            tick();
            ev = exp_q.pop_front();
            edges = j;
            n_tests++; if (m_instr !== ev) begin n_fail++; $display("FAIL to_instr[%0d]: got %h exp %h", j, m_instr, ev); end
            if (m_cpu_nrst === 1'b0) done = 1'b1;
        end
        n_tests++; if (!done || edges != 899) begin n_fail++; $display("FAIL to_edge: got done=%b edges=%0d exp 1/899", done, edges); end
        n_tests++; if (m_timeout !== 1'b1 || m_halted !== 1'b0) begin n_fail++; $display("FAIL to_flags: got to=%b h=%b exp 1/0", m_timeout, m_halted); end
        n_tests++; if (m_cycles !== 24'd899) begin n_fail++; $display("FAIL to_cycles: got %0d exp 899", m_cycles); end
        tick();
        n_tests++; if (m_cycles !== 24'd899 || m_cpu_nrst !== 1'b0) begin n_fail++; $display("FAIL to_frozen: got cyc=%0d nrst=%b exp 899/0", m_cycles, m_cpu_nrst); end
        // second run: HALT lands on the same edge as the watchdog
        m_pc = '0; m_run_start = 1'b1; tick(); m_run_start = 1'b0;
        for (int j = 1; j <= 899; j++) begin
            m_pc = (j >= 898) ? 10'd1 : 10'd0;
            exp_q.push_back(mm[m_pc]);
            tick();
            ev = exp_q.pop_front();
            n_tests++; if (m_instr !== ev) begin n_fail++; $display("FAIL tie_instr[%0d]: got %h exp %h", j, m_instr, ev); end
            if (j == 898) begin
                n_tests++; if (m_halted !== 1'b0 || m_cpu_nrst !== 1'b1) begin n_fail++; $display("FAIL tie_early: got h=%b nrst=%b exp 0/1", m_halted, m_cpu_nrst); end
            end
        end
        n_tests++; if (m_halted !== 1'b1 || m_timeout !== 1'b0) begin n_fail++; $display("FAIL tie_priority: got h=%b to=%b exp 1/0", m_halted, m_timeout); end
        n_tests++; if (m_cycles !== 24'd899 || m_cpu_nrst !== 1'b0) begin n_fail++; $display("FAIL tie_end: got cyc=%0d nrst=%b exp 899/0", m_cycles, m_cpu_nrst); end
    endtask

    initial begin
        m_load_start = 0; m_load_valid = 0; m_load_last = 0; m_run_start = 0; m_load_data = '0; m_pc = '0;
        s_load_start = 0; s_load_valid = 0; s_load_last = 0; s_run_start = 0; s_load_data = '0; s_pc = '0;
        test_reset();
        test_overflow();
        test_load();
        test_run_halt();
        test_restart();
        test_rst_mid();
        test_same_cycle_oob();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no completion exp finish before 200000ns");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter A_BITS, default 10, instruction address width.
REQ-002 Parameter I_BITS, default 16, instruction word width.
REQ-003 Parameter OP_BITS, default 7, opcode field width, taken as instr[I_BITS-1 -: OP_BITS].
REQ-004 Parameter HALT_OPC, default 7'h7F, opcode value that terminates a run.
REQ-005 Parameter CNT_BITS, default 24, run-cycle counter width.
REQ-006 Parameter MAX_CYCLES, default 900, watchdog limit in run cycles; value 0 disables the watchdog.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 load_start  in  1  pulse that begins a program load.
REQ-010 load_valid  in  1  load_data is valid this cycle.
REQ-011 load_ready  out  1  block accepts a load word this cycle.
REQ-012 load_data  in  I_BITS  program word.
REQ-013 load_last  in  1  qualifies the final word of the program.
REQ-014 run_start  in  1  pulse that begins or restarts execution.
REQ-015 pc  in  A_BITS  fetch address from the core.
REQ-016 instr  out  I_BITS  fetched instruction, registered.
REQ-017 cpu_nrst  out  1  active-low core reset; deasserted only in RUN.
REQ-018 prog_len  out  A_BITS+1  number of words loaded.
REQ-019 halted  out  1  run ended on HALT_OPC.
REQ-020 timeout  out  1  run ended on the watchdog.
REQ-021 err_ovf  out  1  sticky flag: load filled memory without load_last.
REQ-022 err_oob  out  1  sticky flag: fetch at or beyond prog_len during RUN.
REQ-023 cycles  out  CNT_BITS  clock cycles spent in RUN in the current or last run.

Function
REQ-024 Storage is 2**A_BITS words of I_BITS bits, one write port (loader) and one registered read port (fetch).
REQ-025 FSM states are IDLE, LOAD, RUN and HALTED.
REQ-026 IDLE: load_start goes to LOAD, clears wr_ptr, prog_len, err_ovf and err_oob; if it coincides with run_start, load_start wins.
REQ-027 IDLE: run_start with prog_len!=0 goes to RUN, clears cycles, halted and timeout; with prog_len==0 it is ignored.
REQ-028 LOAD: load_ready=1; load_valid writes load_data at wr_ptr and increments wr_ptr.
REQ-029 LOAD: an accepted word with load_last=1 sets prog_len=wr_ptr+1 and goes to IDLE.
REQ-030 LOAD: an accepted word at wr_ptr=2**A_BITS-1 without load_last sets prog_len=2**A_BITS, sets err_ovf=1 and goes to IDLE.
REQ-031 load_ready=0 in every state other than LOAD; load_valid outside LOAD has no effect.
REQ-032 RUN: instr shall equal mem[pc] one cycle after pc is presented (latency 1).
REQ-033 RUN: if pc>=prog_len, instr=0 (NOP) and err_oob is set.
REQ-034 RUN: cycles increments every cycle and saturates at 2**CNT_BITS-1.
REQ-035 RUN: a registered instr with opcode HALT_OPC goes to HALTED with halted=1 on the next edge.
REQ-036 RUN: cycles==MAX_CYCLES-1 (MAX_CYCLES!=0) goes to HALTED with timeout=1; if this coincides with HALT detection, halted has priority and timeout stays 0.
REQ-037 RUN/HALTED: load_start is ignored.
REQ-038 HALTED: instr is held, cycles is frozen, run_start re-enters RUN per REQ-027.
REQ-039 cpu_nrst is a registered output, 1 exactly in cycles when the state is RUN; HALTED drops it on the transition edge.
REQ-040 Memory contents persist across runs and across rst; only a new load modifies them.

Reset
REQ-041 While rst=1: state=IDLE, instr=0, cpu_nrst=0, load_ready=0, prog_len=0, cycles=0, halted=0, timeout=0, err_ovf=0, err_oob=0, wr_ptr=0.
REQ-042 rst during LOAD aborts the load: prog_len=0, so run_start is ignored until a new load completes.
REQ-043 rst during RUN asserts cpu_nrst=0 asynchronously and loses cycles and flags.

Verification
REQ-044 Load 14 words with load_last on word 13, word 13 opcode HALT_OPC -> prog_len=14, load_ready=0 after the last word, err_ovf=0.
REQ-045 run_start, bench drives pc=0..13 one per cycle -> instr tracks mem[pc-1 cycle], halted=1 two cycles after pc=13, cpu_nrst=0, cycles=15.
REQ-046 Program with no HALT_OPC, MAX_CYCLES=900, pc held at 0 -> timeout=1, halted=0, cycles=899, state HALTED.
REQ-047 A_BITS=3, load 8 words without load_last -> err_ovf=1, prog_len=8, state IDLE; a 9th load_valid is not accepted.
REQ-048 prog_len=4, drive pc=6 in RUN -> instr=0, err_oob=1 (sticky until next load_start).
REQ-049 load_start and run_start in the same IDLE cycle -> LOAD entered; assert rst mid-RUN -> cpu_nrst=0 immediately, all outputs at reset values.
